uart_rx_datapath: RTL and testbench
===================================

# uart_rx_datapath

Receive datapath of the full UART. It consumes the bit-timing strobes produced by the RX bit-time/bit-count controller (BTU, START, DONE) and shifts in the serial line at mid-bit. On frame completion it extracts the 7- or 8-bit character, checks parity, stop bit and overrun, and presents the result with a ready flag to the processor-side register interface.

## Interface
Parameters: none. Frame format is selected at run time by EIGHT/PEN/OHEL.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- RX  in  1  serial line; the same synchronized signal the RX controller sees
- BTU  in  1  bit-time-up strobe, one clk wide, at mid-bit
- START  in  1  high while the controller is qualifying the start bit (half-bit phase)
- DONE  in  1  frame complete; may stay high for more than one cycle
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
- PEN  in  1  parity enable
- OHEL  in  1  parity sense: 0 = even, 1 = odd
- READ_ACK  in  1  one-cycle strobe; processor has read DATA/status
- DATA  out  8  received character, right-justified; bit 7 = 0 in 7-bit modes
- RXRDY  out  1  character available
- PERR  out  1  parity error on the latched character
- FERR  out  1  framing error (stop bit sampled 0)
- OVF  out  1  overrun: new character latched while RXRDY was still 1

## Operation
- Shift register SR[9:0]:
  - cleared to 0 while START=1
  - when BTU=1 and START=0: SR <= {RX, SR[9:1]} (LSB-first line, new bit enters at bit 9)
  - otherwise holds
- A BTU with START=1 is the mid-start sample and is not shifted.
- Shifts per frame, N: 7N=8, 7P=9, 8N=9, 8P=10 (data + optional parity + stop). Aligned word A = SR >> (10−N).
- Field extraction from A:
  - 7N: data=A[6:0], stop=A[7]
  - 7P: data=A[6:0], par=A[7], stop=A[8]
  - 8N: data=A[7:0], stop=A[8]
  - 8P: data=A[7:0], par=A[8], stop=A[9]
- Checks:
  - PERR = PEN & (^data ^ par ^ OHEL)
  - FERR = ~stop
- Completion event: DONE rising edge, detected against a registered copy of DONE (done_rise = DONE & ~done_q). Additional DONE-high cycles are ignored.
- On done_rise:
  - DATA <= data, zero-extended
  - PERR and FERR <= computed values
  - OVF <= RXRDY (prior value)
  - RXRDY <= 1
- On READ_ACK without done_rise: RXRDY, PERR, FERR and OVF clear to 0. DATA holds.
- READ_ACK and done_rise in the same cycle: done_rise wins; the new character is latched, RXRDY stays 1, and OVF=0 because the old character was read.
- EIGHT/PEN/OHEL are static during a frame; they are used as sampled in the done_rise cycle.
- False start: the controller drops START without reaching DONE. SR may hold stale bits; no outputs change.

## Timing
- Reset values: SR=0, done_q=0, DATA=8'h00, RXRDY=0, PERR=0, FERR=0, OVF=0.
- Reset mid-frame clears everything immediately. The frame in progress is lost and produces no RXRDY.
- SR updates on the clk edge where BTU=1; the sample is RX at that edge.
- Latency: DATA and status outputs are valid on the clk edge following the first DONE-high cycle (1 cycle after DONE rises). All outputs are registered.
- RXRDY stays high until READ_ACK and has no timeout.
- OVF, PERR and FERR are sticky until READ_ACK or the next done_rise.
- Back-to-back frames need only the next START to clear SR. The minimum START-to-DONE spacing guaranteed by the controller exceeds 2 cycles.

## Test plan
- 8N, send 0xA5 (bits 1,0,1,0,0,1,0,1, stop 1) -> DATA=0xA5, RXRDY=1, PERR=FERR=OVF=0, one cycle after DONE rises.
- 8P odd, send 0x0F with parity bit 0 and stop 1 -> DATA=0x0F, PERR=1. Repeat with parity bit 1 -> PERR=0.
- 7N, send 0x41 with stop bit 0 -> DATA=0x41, bit 7=0, FERR=1. 7P even, 0x41 with parity 0 -> PERR=0.
- Two 8N frames (0x12, then 0x34) with no READ_ACK -> DATA=0x34, RXRDY=1, OVF=1. Then READ_ACK -> RXRDY=OVF=0, DATA=0x34.
- READ_ACK in the same cycle as done_rise of the second frame -> RXRDY=1, OVF=0, DATA=second byte. Hold DONE high for 2 cycles -> exactly one latch and no OVF from the second DONE cycle.
- Assert rst mid-frame after 4 BTUs, then send a full 8N frame 0x5A -> all outputs 0 during reset; after the frame DATA=0x5A, RXRDY=1. False start (START drops, no DONE) -> outputs unchanged.

Source files
------------

// File: rtl/uart_rx_datapath_if.sv
// Signal bundle between the RX bit-timing controller/processor side and the RX datapath.
// The master drives the line, strobes and frame format. The slave returns the character and its status.
interface uart_rx_datapath_if;
  logic       RX;
  logic       BTU;
  logic       START;
  logic       DONE;
  logic       EIGHT;
  logic       PEN;
  logic       OHEL;
  logic       READ_ACK;
  logic [7:0] DATA;
  logic       RXRDY;
  logic       PERR;
  logic       FERR;
  logic       OVF;

  modport master (
    output RX, BTU, START, DONE, EIGHT, PEN, OHEL, READ_ACK,
    input  DATA, RXRDY, PERR, FERR, OVF
  );

  modport slave (
    input  RX, BTU, START, DONE, EIGHT, PEN, OHEL, READ_ACK,
    output DATA, RXRDY, PERR, FERR, OVF
  );
endinterface

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: shifts the line in at mid-bit, then latches the character
// together with parity, framing and overrun status on the rising edge of DONE.
module uart_rx_datapath (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_datapath_if.slave    rx_if
);

  logic [9:0] sr;
  logic       done_q;
  logic [7:0] data_q;
  logic       rxrdy_q;
  logic       perr_q;
  logic       ferr_q;
  logic       ovf_q;

  logic [7:0] data_c;
  logic       par_c;
  logic       stop_c;
  logic       perr_c;
  logic       done_rise;

  assign done_rise = rx_if.DONE & ~done_q;

  // The last bit shifted in always sits at sr[9], so the stop bit never moves.
  always_comb begin
    data_c = 8'h00;
    par_c  = 1'b0;
    stop_c = sr[9];
    unique case ({rx_if.EIGHT, rx_if.PEN})
      2'b00: data_c = {1'b0, sr[8:2]};
      2'b01: begin
        data_c = {1'b0, sr[7:1]};
        par_c  = sr[8];
      end
      2'b10: data_c = sr[8:1];
      2'b11: begin
        data_c = sr[7:0];
        par_c  = sr[8];
      end
      default: data_c = 8'h00;
    endcase
    perr_c = rx_if.PEN & (^data_c ^ par_c ^ rx_if.OHEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= 10'h000;
      done_q <= 1'b0;
    end else begin
      done_q <= rx_if.DONE;
      if (rx_if.START)
        sr <= 10'h000;
      else if (rx_if.BTU)
        sr <= {rx_if.RX, sr[9:1]};
    end
  end

  // A new character takes priority over a read in the same cycle.
  // Overrun is then cleared because the old character was consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (done_rise) begin
      data_q  <= data_c;
      rxrdy_q <= 1'b1;
      perr_q  <= perr_c;
      ferr_q  <= ~stop_c;
      ovf_q   <= rxrdy_q & ~rx_if.READ_ACK;
    end else if (rx_if.READ_ACK) begin
      rxrdy_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign rx_if.DATA  = data_q;
  assign rx_if.RXRDY = rxrdy_q;
  assign rx_if.PERR  = perr_q;
  assign rx_if.FERR  = ferr_q;
  assign rx_if.OVF   = ovf_q;

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: directed frames, a character-level model of the outputs
// checked every cycle, plus literal expectations after key frames.
module tb_uart_rx_datapath;

  logic clk;
  logic rst;
  uart_rx_datapath_if bus ();

  uart_rx_datapath dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data;
  logic       exp_rxrdy, exp_perr, exp_ferr, exp_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_data",  bus.DATA,           exp_data);
    chk("cyc_rxrdy", {7'b0, bus.RXRDY},  {7'b0, exp_rxrdy});
    chk("cyc_perr",  {7'b0, bus.PERR},   {7'b0, exp_perr});
    chk("cyc_ferr",  {7'b0, bus.FERR},   {7'b0, exp_ferr});
    chk("cyc_ovf",   {7'b0, bus.OVF},    {7'b0, exp_ovf});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_data  = 8'h00;
    exp_rxrdy = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  // Character-level view: what the receiver must report for a given transmitted frame.
  task automatic model_frame(input bit e8, input bit pen, input bit ohel, input logic [7:0] d,
                             input bit par, input bit stop, input bit ack);
    logic [7:0] ch;
    logic       want_par;
    ch        = e8 ? d : (d & 8'h7F);
    want_par  = (^ch) ^ ohel;
    exp_ovf   = exp_rxrdy && !ack;
    exp_data  = ch;
    exp_perr  = pen && (par != want_par);
    exp_ferr  = !stop;
    exp_rxrdy = 1'b1;
  endtask

  task automatic start_phase();
    bus.START = 1'b1;
    tick();
    bus.BTU = 1'b1;
    tick();
    bus.BTU = 1'b0;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    bus.RX  = b;
    bus.BTU = 1'b1;
    tick();
    bus.BTU = 1'b0;
    bus.RX  = ~b;
    tick();
    tick();
  endtask

  task automatic send_frame(input bit e8, input bit pen, input bit ohel, input logic [7:0] d,
                            input bit par, input bit stop, input int hold, input bit ack);
    bus.EIGHT = e8;
    bus.PEN   = pen;
    bus.OHEL  = ohel;
    start_phase();
    for (int i = 0; i < (e8 ? 8 : 7); i++) send_bit(d[i]);
    if (pen) send_bit(par);
    send_bit(stop);
    bus.DONE     = 1'b1;
    bus.READ_ACK = ack;
    tick();
    model_frame(e8, pen, ohel, d, par, stop, ack);
    bus.READ_ACK = 1'b0;
    for (int i = 1; i < hold; i++) tick();
    bus.DONE = 1'b0;
    tick();
  endtask

  task automatic read_ack();
    bus.READ_ACK = 1'b1;
    tick();
    exp_rxrdy = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
    bus.READ_ACK = 1'b0;
    tick();
  endtask

  task automatic partial_frame(input int nbits, input logic [7:0] pat);
    start_phase();
    for (int i = 0; i < nbits; i++) send_bit(pat[i]);
  endtask

  task automatic chk_status(input string tag, input logic [7:0] d, input bit rdy,
                            input bit pe, input bit fe, input bit ov);
    chk({tag, "_data"},  bus.DATA,          d);
    chk({tag, "_rxrdy"}, {7'b0, bus.RXRDY}, {7'b0, rdy});
    chk({tag, "_perr"},  {7'b0, bus.PERR},  {7'b0, pe});
    chk({tag, "_ferr"},  {7'b0, bus.FERR},  {7'b0, fe});
    chk({tag, "_ovf"},   {7'b0, bus.OVF},   {7'b0, ov});
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.RX = 1'b1; bus.BTU = 1'b0; bus.START = 1'b0; bus.DONE = 1'b0;
    bus.EIGHT = 1'b1; bus.PEN = 1'b0; bus.OHEL = 1'b0; bus.READ_ACK = 1'b0;
    clear_model();
    #1;
    chk_status("reset", 8'h00, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    send_frame(1, 0, 0, 8'hA5, 0, 1, 1, 0);
    chk_status("a5", 8'hA5, 1, 0, 0, 0);
    chk("model_a5", exp_data, 8'hA5);
    read_ack();

    send_frame(1, 1, 1, 8'h0F, 0, 1, 1, 0);
    chk_status("odd_p0", 8'h0F, 1, 1, 0, 0);
    chk("model_odd_p0", {7'b0, exp_perr}, 8'h01);
    read_ack();
    send_frame(1, 1, 1, 8'h0F, 1, 1, 1, 0);
    chk_status("odd_p1", 8'h0F, 1, 0, 0, 0);
    read_ack();

    send_frame(0, 0, 0, 8'h41, 0, 0, 1, 0);
    chk_status("7n_ferr", 8'h41, 1, 0, 1, 0);
    read_ack();
    send_frame(0, 1, 0, 8'h41, 0, 1, 1, 0);
    chk_status("7p_even", 8'h41, 1, 0, 0, 0);
    read_ack();

    send_frame(1, 0, 0, 8'h12, 0, 1, 1, 0);
    send_frame(1, 0, 0, 8'h34, 0, 1, 1, 0);
    chk_status("ovr", 8'h34, 1, 0, 0, 1);
    chk("model_ovr", {7'b0, exp_ovf}, 8'h01);
    read_ack();
    chk_status("ovr_ack", 8'h34, 0, 0, 0, 0);

    send_frame(1, 0, 0, 8'h56, 0, 1, 1, 0);
    send_frame(1, 0, 0, 8'h78, 0, 1, 2, 1);
    chk_status("ack_done", 8'h78, 1, 0, 0, 0);

    partial_frame(4, 8'b0000_1011);
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    chk_status("mid_rst", 8'h00, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    send_frame(1, 0, 0, 8'h5A, 0, 1, 1, 0);
    chk_status("after_rst", 8'h5A, 1, 0, 0, 0);

    partial_frame(3, 8'b0000_0110);
    repeat (4) tick();
    chk_status("false_start", 8'h5A, 1, 0, 0, 0);

    send_frame(1, 1, 0, 8'h3C, 0, 1, 1, 0);
    chk_status("8p_even", 8'h3C, 1, 0, 0, 1);
    read_ack();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
